// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared FSM state type and seven-segment glyphs for calc_ctrl
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_B = 2'd1,
      EXEC   = 2'd2,
      SHOW   = 2'd3
   } state_t;

   // Segment order {a,b,c,d,e,f,g,dp}, active high
   localparam logic [7:0] ONE   = 8'b01100000;
   localparam logic [7:0] ZERO  = 8'b11111100;
   localparam logic [7:0] BLANK = 8'h00;
   localparam logic [7:0] MINUS = 8'b00000010;

   function automatic logic [7:0] bit_glyph(input logic b);
      return b ? ONE : ZERO;
   endfunction

endpackage

// File: rtl/calc_addsub.sv
// rtl/calc_addsub.sv - 4-bit ripple add/subtract; c[4] is carry on add, borrow on subtract
module calc_addsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       mo,
   output logic [4:0] c
);

   logic [4:0] cy;
   logic [3:0] bx;
   logic [3:0] s;

   assign cy[0] = mo;
   assign bx    = b ^ {4{mo}};

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]      = a[i] ^ bx[i] ^ cy[i];
      assign cy[i + 1] = (a[i] & bx[i]) | (cy[i] & (a[i] ^ bx[i]));
   end

   // On subtract the adder carry-out means "no borrow", so invert it
   assign c = {cy[4] ^ mo, s};

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - two-operand calculator FSM with scanned 8-digit display; option CALC_CTRL_SIGN_DISP_EN
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1024
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic [3:0] din,
   input  logic       op,
   input  logic       key_valid,
   input  logic       cancel,
   output logic [4:0] result,
   output logic       busy,
   output logic       done,
   output logic [7:0] seg,
   output logic [7:0] dig
);

   localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

   state_t      state_q, state_d;
   logic [3:0]  a_q, a_d;
   logic [3:0]  b_q, b_d;
   logic        op_q, op_d;
   logic [4:0]  result_q, result_d;
   logic        done_q, done_d;
   logic [15:0] presc_q, presc_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  seg_q, seg_d;
   logic [7:0]  dig_q, dig_d;

   logic [4:0]  sum;
   logic [4:0]  result_calc;
   logic        abort;
   logic [7:0]  res_ext;
   logic [7:0]  a_ext;

   calc_addsub u_addsub (
      .a  (a_q),
      .b  (b_q),
      .mo (op_q),
      .c  (sum)
   );

`ifdef CALC_CTRL_SIGN_DISP_EN
   // Negative differences are presented as sign plus magnitude
   always_comb begin
      result_calc = sum;
      if (op_q && sum[4]) begin
         result_calc[3:0] = 4'd0 - sum[3:0];
      end
   end
`else
   assign result_calc = sum;
`endif

   // Cancel is honoured everywhere except the single EXEC cycle
   assign abort = cancel && (state_q != EXEC);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (key_valid) state_d = WAIT_B;
            WAIT_B:  if (key_valid) state_d = EXEC;
            EXEC:    state_d = SHOW;
            SHOW:    if (key_valid) state_d = WAIT_B;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      done_d   = 1'b0;
      if (abort) begin
         a_d  = 4'd0;
         b_d  = 4'd0;
         op_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, SHOW: begin
               if (key_valid) a_d = din;
            end
            WAIT_B: begin
               if (key_valid) begin
                  b_d  = din;
                  op_d = op;
               end
            end
            EXEC: begin
               result_d = result_calc;
               done_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Display registers are computed from next-cycle values so seg always matches dig
   always_comb begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = 16'd0;
         idx_d   = idx_q + 3'd1;
      end
      dig_d   = 8'b0000_0001 << idx_d;
      res_ext = {3'b000, result_d};
      a_ext   = {4'b0000, a_d};
      seg_d   = BLANK;
      case (state_d)
         SHOW: begin
            if (idx_d < 3'd5) begin
               seg_d = bit_glyph(res_ext[idx_d]);
            end
`ifdef CALC_CTRL_SIGN_DISP_EN
            else if (idx_d == 3'd7 && op_d && result_d[4]) begin
               seg_d = MINUS;
            end
`endif
         end
         WAIT_B: begin
            if (idx_d < 3'd4) begin
               seg_d = bit_glyph(a_ext[idx_d]);
            end
         end
         default: seg_d = BLANK;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         op_q     <= 1'b0;
         result_q <= 5'd0;
         done_q   <= 1'b0;
         presc_q  <= 16'd0;
         idx_q    <= 3'd0;
         seg_q    <= BLANK;
         dig_q    <= 8'b0000_0001;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         done_q   <= done_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
      end
   end

   assign busy   = (state_q == EXEC);
   assign done   = done_q;
   assign result = result_q;
   assign seg    = seg_q;
   assign dig    = dig_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl with SCAN_DIV = 4
module tb_calc_ctrl;

   localparam logic [7:0] G1 = 8'b01100000;
   localparam logic [7:0] G0 = 8'b11111100;
   localparam logic [7:0] GB = 8'h00;
   localparam logic [7:0] GM = 8'b00000010;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic [3:0] din = 4'd0;
   logic       op = 1'b0;
   logic       key_valid = 1'b0;
   logic       cancel = 1'b0;
   logic [4:0] result;
   logic       busy;
   logic       done;
   logic [7:0] seg;
   logic [7:0] dig;

   int total = 0;
   int bad = 0;

   calc_ctrl #(.SCAN_DIV(4)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .din       (din),
      .op        (op),
      .key_valid (key_valid),
      .cancel    (cancel),
      .result    (result),
      .busy      (busy),
      .done      (done),
      .seg       (seg),
      .dig       (dig)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic key(input logic [3:0] d, input logic o);
      din = d;
      op = o;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
   endtask

   task automatic wait_dig(input logic [7:0] t);
      int n = 0;
      while (dig !== t && n < 40) begin
         step();
         n++;
      end
      chk("wait_dig", dig, t);
   endtask

   task automatic seg_at(input string tag, input logic [7:0] mask, input logic [7:0] exp);
      wait_dig(mask);
      chk(tag, seg, exp);
   endtask

   initial begin
      logic [7:0] e;
      #2 CLR = 1'b0;
      step();
      step();
      chk("rst_result", {3'b0, result}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_done", {7'b0, done}, 8'h00);
      chk("rst_seg", seg, 8'h00);
      chk("rst_dig", dig, 8'h01);

      // Free-running scan from reset release: each digit held 4 cycles
      CLR = 1'b1;
      chk("scan_0", dig, 8'h01);
      for (int k = 1; k < 36; k++) begin
         step();
         e = 8'h01 << ((k / 4) % 8);
         chk("scan", dig, e);
         chk("idle_seg", seg, GB);
      end

      // 9 + 8 = 17
      key(4'd9, 1'b0);
      seg_at("wb9_d0", 8'h01, G1);
      seg_at("wb9_d1", 8'h02, G0);
      seg_at("wb9_d3", 8'h08, G1);
      seg_at("wb9_d4", 8'h10, GB);
      key(4'd8, 1'b0);
      chk("add_busy", {7'b0, busy}, 8'h01);
      chk("add_done_early", {7'b0, done}, 8'h00);
      step();
      chk("add_busy_off", {7'b0, busy}, 8'h00);
      chk("add_done", {7'b0, done}, 8'h01);
      chk("add_result", {3'b0, result}, 8'h11);
      step();
      chk("add_done_pulse", {7'b0, done}, 8'h00);
      chk("add_hold", {3'b0, result}, 8'h11);

      // 2 + 3 = 5: glyph content in SHOW
      key(4'd2, 1'b0);
      key(4'd3, 1'b0);
      step();
      chk("r5", {3'b0, result}, 8'h05);
      seg_at("sh5_d0", 8'h01, G1);
      seg_at("sh5_d1", 8'h02, G0);
      seg_at("sh5_d2", 8'h04, G1);
      seg_at("sh5_d5", 8'h20, GB);
      seg_at("sh5_d6", 8'h40, GB);
      seg_at("sh5_d7", 8'h80, GB);

      // 3 - 5
      key(4'd3, 1'b0);
      key(4'd5, 1'b1);
      step();
`ifdef CALC_CTRL_SIGN_DISP_EN
      chk("sub_result", {3'b0, result}, 8'h12);
      seg_at("sub_d7", 8'h80, GM);
`else
      chk("sub_result", {3'b0, result}, 8'h1e);
      seg_at("sub_d7", 8'h80, GB);
`endif
      seg_at("sub_d4", 8'h10, G1);

      // key during EXEC is dropped
      key(4'd4, 1'b0);
      key(4'd1, 1'b0);
      chk("ex_busy", {7'b0, busy}, 8'h01);
      key(4'd6, 1'b0);
      chk("ex_done", {7'b0, done}, 8'h01);
      chk("ex_result", {3'b0, result}, 8'h05);
      seg_at("ex_d4", 8'h10, G0);
      seg_at("ex_d0", 8'h01, G1);

      // cancel beats key in WAIT_B
      key(4'd5, 1'b0);
      cancel = 1'b1;
      key_valid = 1'b1;
      din = 4'd9;
      step();
      cancel = 1'b0;
      key_valid = 1'b0;
      chk("cx_busy", {7'b0, busy}, 8'h00);
      seg_at("cx_d0", 8'h01, GB);
      chk("cx_result", {3'b0, result}, 8'h05);
      key(4'd3, 1'b0);
      seg_at("re_d0", 8'h01, G1);
      seg_at("re_d1", 8'h02, G1);
      seg_at("re_d2", 8'h04, G0);
      key(4'd4, 1'b0);
      step();
      chk("re_done", {7'b0, done}, 8'h01);
      chk("re_result", {3'b0, result}, 8'h07);

      // cancel in SHOW
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      seg_at("cs_d0", 8'h01, GB);
      chk("cs_result", {3'b0, result}, 8'h07);

      // reset during EXEC
      key(4'd6, 1'b0);
      key(4'd7, 1'b0);
      chk("rx_busy", {7'b0, busy}, 8'h01);
      #2 CLR = 1'b0;
      #1;
      chk("rx_busy_off", {7'b0, busy}, 8'h00);
      chk("rx_result", {3'b0, result}, 8'h00);
      chk("rx_done", {7'b0, done}, 8'h00);
      chk("rx_dig", dig, 8'h01);
      chk("rx_seg", seg, 8'h00);
      step();
      chk("rx_done_edge", {7'b0, done}, 8'h00);
      CLR = 1'b1;
      step();
      chk("rx_done_after", {7'b0, done}, 8'h00);
      chk("rx_idle", {7'b0, busy}, 8'h00);
      chk("rx_result_after", {3'b0, result}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
